// File: rtl/usb_fs_pkg.sv
// Shared encodings and limits for the full-speed USB receive path.
package usb_fs_pkg;

  // Line-state encoding is {D-, D+}
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ABORT
  } rx_state_t;

  localparam int STUFF_LIMIT    = 6;
  localparam int SYNC_MIN_ZEROS = 5;
  localparam int EOP_MAX_SE0    = 3;

  // True for the two differential data levels (J or K)
  function automatic logic is_jk(input logic [1:0] ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_fs_dpll.sv
// Pin synchronisers, registered line state and the 4x oversampling phase tracker.
module usb_fs_dpll
  import usb_fs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_p,
  input  logic       d_n,
  output logic [1:0] line_state,
  output logic       strobe
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_n;
  logic [1:0]             synced;
  logic [1:0]             phase;
  logic                   jk_edge;

  assign synced  = {sync_n[SYNC_STAGES-1], sync_p[SYNC_STAGES-1]};
  assign jk_edge = is_jk(synced) && is_jk(line_state) && (synced != line_state);
  assign strobe  = (phase == 2'd2);

  // Synchronise both pins and register the combined line state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p     <= '0;
      sync_n     <= '0;
      line_state <= LS_SE0;
    end else begin
      sync_p     <= {sync_p[SYNC_STAGES-2:0], d_p};
      sync_n     <= {sync_n[SYNC_STAGES-2:0], d_n};
      line_state <= synced;
    end
  end

  // Free-running phase counter, re-centred on every J<->K edge so phase 2 lands mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
    end else begin
      phase <= jk_edge ? 2'd0 : phase + 2'd1;
    end
  end

endmodule

// File: rtl/usb_fs_receiver.sv
// Full-speed USB receive front-end: NRZI decode, SYNC detect, unstuffing, byte assembly, EOP.
module usb_fs_receiver
  import usb_fs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Enable,
  input  logic       USB_D_P,
  input  logic       USB_D_N,
  output logic [1:0] Line_State,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Packet_Start,
  output logic       Packet_End,
  output logic       Packet_Active,
  output logic       Error
);

  rx_state_t  state, state_next;
  logic [1:0] prev_level, prev_level_next;
  logic [2:0] zero_cnt, zero_cnt_next;
  logic [2:0] ones_cnt, ones_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [1:0] se0_cnt, se0_cnt_next;
  logic [7:0] shift, shift_next;
  logic [7:0] data_next;
  logic       valid_next, start_next, end_next, error_next, active_next;
  logic       strobe;
  logic       sample_jk;
  logic       dec_bit;

  usb_fs_dpll #(.SYNC_STAGES(SYNC_STAGES)) u_dpll (
    .clk        (Clk),
    .rst_n      (nReset),
    .d_p        (USB_D_P),
    .d_n        (USB_D_N),
    .line_state (Line_State),
    .strobe     (strobe)
  );

  assign sample_jk = is_jk(Line_State);
  assign dec_bit   = (Line_State == prev_level);

  // Decoder FSM: next state, unstuffing, byte assembly and output pulses
  always_comb begin
    state_next      = state;
    prev_level_next = prev_level;
    zero_cnt_next   = zero_cnt;
    ones_cnt_next   = ones_cnt;
    bit_cnt_next    = bit_cnt;
    se0_cnt_next    = se0_cnt;
    shift_next      = shift;
    data_next       = Data;
    valid_next      = 1'b0;
    start_next      = 1'b0;
    end_next        = 1'b0;
    error_next      = 1'b0;
    active_next     = Packet_Active;
    if (!Enable) begin
      state_next      = IDLE;
      prev_level_next = LS_J;
      active_next     = 1'b0;
    end else if (strobe) begin
      if (sample_jk) prev_level_next = Line_State;
      unique case (state)
        IDLE: begin
          prev_level_next = LS_J;
          if (Line_State == LS_K) begin
            state_next      = SYNC;
            prev_level_next = LS_K;
            zero_cnt_next   = 3'd1;
          end
        end
        SYNC: begin
          if (!sample_jk) begin
            state_next = IDLE;
          end else if (!dec_bit) begin
            zero_cnt_next = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
          end else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
            // The trailing 1 of SYNC already counts towards the stuffing run
            state_next    = DATA;
            start_next    = 1'b1;
            active_next   = 1'b1;
            ones_cnt_next = 3'd1;
            bit_cnt_next  = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
        DATA: begin
          if (Line_State == LS_SE0) begin
            state_next   = EOP;
            se0_cnt_next = 2'd1;
          end else if (Line_State == LS_SE1) begin
            state_next  = ABORT;
            error_next  = 1'b1;
            active_next = 1'b0;
          end else if (ones_cnt == 3'(STUFF_LIMIT)) begin
            if (dec_bit) begin
              state_next  = ABORT;
              error_next  = 1'b1;
              active_next = 1'b0;
            end else begin
              ones_cnt_next = 3'd0;
            end
          end else begin
            ones_cnt_next = dec_bit ? ones_cnt + 3'd1 : 3'd0;
            shift_next    = {dec_bit, shift[7:1]};
            bit_cnt_next  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_next  = shift_next;
              valid_next = 1'b1;
            end
          end
        end
        EOP: begin
          if (Line_State == LS_J) begin
            state_next  = IDLE;
            end_next    = 1'b1;
            error_next  = (bit_cnt != 3'd0);
            active_next = 1'b0;
          end else if ((Line_State == LS_SE0) && (se0_cnt != 2'(EOP_MAX_SE0))) begin
            se0_cnt_next = se0_cnt + 2'd1;
          end else begin
            state_next  = ABORT;
            error_next  = 1'b1;
            active_next = 1'b0;
          end
        end
        ABORT: begin
          active_next = 1'b0;
          if (Line_State == LS_J) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      prev_level    <= LS_J;
      zero_cnt      <= 3'd0;
      ones_cnt      <= 3'd0;
      bit_cnt       <= 3'd0;
      se0_cnt       <= 2'd0;
      shift         <= 8'd0;
      Data          <= 8'd0;
      Valid         <= 1'b0;
      Packet_Start  <= 1'b0;
      Packet_End    <= 1'b0;
      Packet_Active <= 1'b0;
      Error         <= 1'b0;
    end else begin
      state         <= state_next;
      prev_level    <= prev_level_next;
      zero_cnt      <= zero_cnt_next;
      ones_cnt      <= ones_cnt_next;
      bit_cnt       <= bit_cnt_next;
      se0_cnt       <= se0_cnt_next;
      shift         <= shift_next;
      Data          <= data_next;
      Valid         <= valid_next;
      Packet_Start  <= start_next;
      Packet_End    <= end_next;
      Packet_Active <= active_next;
      Error         <= error_next;
    end
  end

endmodule

// File: tb/tb_usb_fs_receiver.sv
// Directed bench: NRZI/bit-stuffing line encoder, byte scoreboard and event counters.
module tb_usb_fs_receiver;

  localparam logic [1:0] LV_SE0 = 2'b00;
  localparam logic [1:0] LV_J   = 2'b01;
  localparam logic [1:0] LV_K   = 2'b10;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       Enable = 1'b0;
  logic       USB_D_P = 1'b1;
  logic       USB_D_N = 1'b0;
  logic [1:0] Line_State;
  logic [7:0] Data;
  logic       Valid, Packet_Start, Packet_End, Packet_Active, Error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0, n_start = 0, n_end = 0, n_err = 0, n_end_err = 0;
  int t_start = 0, t_end = 0;
  int valid_times[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] exp_b;
  logic [1:0] sym[$];
  logic [1:0] cur;
  int ones;

  usb_fs_receiver #(.SYNC_STAGES(2)) dut (
    .Clk           (Clk),
    .nReset        (nReset),
    .Enable        (Enable),
    .USB_D_P       (USB_D_P),
    .USB_D_N       (USB_D_N),
    .Line_State    (Line_State),
    .Data          (Data),
    .Valid         (Valid),
    .Packet_Start  (Packet_Start),
    .Packet_End    (Packet_End),
    .Packet_Active (Packet_Active),
    .Error         (Error)
  );

  // 48 MHz-ish clock and a cycle counter for latency measurements
  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard monitor: pop an expected byte per Valid and count packet events
  always @(negedge Clk) begin
    if (Valid) begin
      n_valid++;
      valid_times.push_back(cyc);
      total++;
      assert (exp_bytes.size() > 0) else begin
        bad++;
        $error("[TB] FAIL unexpected_valid observed=%02h expected=none", Data);
      end
      if (exp_bytes.size() > 0) begin
        exp_b = exp_bytes.pop_front();
        total++;
        assert (Data === exp_b) else begin
          bad++;
          $error("[TB] FAIL byte_data observed=%02h expected=%02h", Data, exp_b);
        end
      end
      total++;
      assert (Packet_End === 1'b0) else begin
        bad++;
        $error("[TB] FAIL valid_with_end observed=%0b expected=0", Packet_End);
      end
    end
    if (Packet_Start) begin
      n_start++;
      t_start = cyc;
    end
    if (Packet_End) begin
      n_end++;
      t_end = cyc;
      if (Error) n_end_err++;
    end
    if (Error) n_err++;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_start = 0; n_end = 0; n_err = 0; n_end_err = 0;
    valid_times.delete();
  endtask

  // NRZI encoder with USB bit stuffing (run counted from the SYNC's final 1)
  task automatic push_bit(input logic b, input logic stuff_en);
    if (!b) cur = (cur == LV_J) ? LV_K : LV_J;
    sym.push_back(cur);
    if (b) ones++; else ones = 0;
    if (stuff_en && ones == 6) begin
      cur = (cur == LV_J) ? LV_K : LV_J;
      sym.push_back(cur);
      ones = 0;
    end
  endtask

  // Drive grouped runs of equal level; jitter moves each J/K run end by -1..+1 cycle
  task automatic emit(input logic jitter);
    int i = 0;
    int n;
    int d;
    while (i < sym.size()) begin
      n = 1;
      while ((i + n < sym.size()) && (sym[i+n] == sym[i])) n++;
      d = 4 * n;
      if (jitter && (sym[i] != LV_SE0)) d = d + int'($urandom_range(2, 0)) - 1;
      USB_D_P = sym[i][0];
      USB_D_N = sym[i][1];
      repeat (d) @(posedge Clk);
      #1;
      i += n;
    end
  endtask

  // Idle J, SYNC, nbits of tx_bytes LSB first, SE0 SE0, then J idle
  task automatic apply_stimulus(input int nbits, input int nostuff_from, input logic jitter);
    sym.delete();
    cur = LV_J;
    ones = 0;
    for (int i = 0; i < 8; i++) sym.push_back(LV_J);
    for (int i = 0; i < 8; i++) push_bit(i == 7, 1'b1);
    for (int i = 0; i < nbits; i++) push_bit(tx_bytes[i/8][i%8], i < nostuff_from);
    sym.push_back(LV_SE0);
    sym.push_back(LV_SE0);
    for (int i = 0; i < 4; i++) sym.push_back(LV_J);
    emit(jitter);
  endtask

  // Directed test sequence
  initial begin
    wait_cycles(3);
    check_output("rst_line_state", Line_State, 0);
    check_output("rst_data", Data, 0);
    check_output("rst_valid", Valid, 0);
    check_output("rst_start", Packet_Start, 0);
    check_output("rst_end", Packet_End, 0);
    check_output("rst_active", Packet_Active, 0);
    check_output("rst_error", Error, 0);
    nReset = 1'b1;
    Enable = 1'b1;
    wait_cycles(20);
    check_output("idle_line_state_j", Line_State, 1);

    // Single byte 0x2D
    clear_counts();
    tx_bytes = '{8'h2D};
    exp_bytes.push_back(8'h2D);
    apply_stimulus(8, 8, 1'b0);
    wait_cycles(24);
    check_output("p1_start", n_start, 1);
    check_output("p1_valid", n_valid, 1);
    check_output("p1_end", n_end, 1);
    check_output("p1_error", n_err, 0);
    check_output("p1_sb_empty", exp_bytes.size(), 0);
    check_output("p1_active_after", Packet_Active, 0);
    if (valid_times.size() == 1) begin
      check_output("p1_start_to_valid", valid_times[0] - t_start, 32);
      check_output("p1_valid_to_end", t_end - valid_times[0], 12);
    end

    // Stuffed bytes: each carries one stuff bit, so 9 bit periods apart
    clear_counts();
    tx_bytes = '{8'hFF, 8'hFF, 8'h01};
    foreach (tx_bytes[i]) exp_bytes.push_back(tx_bytes[i]);
    apply_stimulus(24, 24, 1'b0);
    wait_cycles(24);
    check_output("p2_valid", n_valid, 3);
    check_output("p2_error", n_err, 0);
    check_output("p2_end", n_end, 1);
    check_output("p2_sb_empty", exp_bytes.size(), 0);
    if (valid_times.size() == 3) begin
      check_output("p2_gap1", valid_times[1] - valid_times[0], 36);
      check_output("p2_gap2", valid_times[2] - valid_times[1], 36);
    end

    // Missing stuff bit in the second byte
    clear_counts();
    tx_bytes = '{8'h00, 8'hFF};
    exp_bytes.push_back(8'h00);
    apply_stimulus(16, 8, 1'b0);
    wait_cycles(24);
    check_output("p3_valid", n_valid, 1);
    check_output("p3_error", n_err, 1);
    check_output("p3_end", n_end, 0);
    check_output("p3_active", Packet_Active, 0);
    check_output("p3_sb_empty", exp_bytes.size(), 0);

    // Recovery after the stuff error
    clear_counts();
    tx_bytes = '{8'h5A};
    exp_bytes.push_back(8'h5A);
    apply_stimulus(8, 8, 1'b0);
    wait_cycles(24);
    check_output("p4_valid", n_valid, 1);
    check_output("p4_end", n_end, 1);
    check_output("p4_error", n_err, 0);

    // Partial byte: 12 data bits then EOP
    clear_counts();
    tx_bytes = '{8'hC3, 8'h0B};
    exp_bytes.push_back(8'hC3);
    apply_stimulus(12, 12, 1'b0);
    wait_cycles(24);
    check_output("p5_valid", n_valid, 1);
    check_output("p5_end", n_end, 1);
    check_output("p5_error", n_err, 1);
    check_output("p5_end_with_error", n_end_err, 1);

    // Random +/-1 cycle edge jitter
    for (int r = 0; r < 3; r++) begin
      clear_counts();
      tx_bytes = '{8'hA5, 8'h3C};
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'h3C);
      apply_stimulus(16, 16, 1'b1);
      wait_cycles(24);
      check_output("jit_valid", n_valid, 2);
      check_output("jit_end", n_end, 1);
      check_output("jit_error", n_err, 0);
      check_output("jit_sb_empty", exp_bytes.size(), 0);
    end

    // Enable dropped during the second byte
    clear_counts();
    tx_bytes = '{8'h11, 8'h22, 8'h33};
    exp_bytes.push_back(8'h11);
    fork
      apply_stimulus(24, 24, 1'b0);
      begin
        wait_cycles(111);
        check_output("en_active_before", Packet_Active, 1);
        Enable = 1'b0;
        wait_cycles(1);
        check_output("en_active_after", Packet_Active, 0);
      end
    join
    wait_cycles(24);
    check_output("en_valid", n_valid, 1);
    check_output("en_end", n_end, 0);
    check_output("en_error", n_err, 0);
    Enable = 1'b1;
    wait_cycles(8);
    clear_counts();
    tx_bytes = '{8'hE7};
    exp_bytes.push_back(8'hE7);
    apply_stimulus(8, 8, 1'b0);
    wait_cycles(24);
    check_output("reen_valid", n_valid, 1);
    check_output("reen_end", n_end, 1);
    check_output("reen_sb_empty", exp_bytes.size(), 0);

    // Reset asserted mid-packet, released while 1-runs continue
    clear_counts();
    tx_bytes = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    exp_bytes.push_back(8'h00);
    fork
      apply_stimulus(32, 32, 1'b0);
      begin
        wait_cycles(119);
        check_output("mr_active_before", Packet_Active, 1);
        nReset = 1'b0;
        #1;
        check_output("mr_line_state", Line_State, 0);
        check_output("mr_data", Data, 0);
        check_output("mr_valid", Valid, 0);
        check_output("mr_active", Packet_Active, 0);
        check_output("mr_error", Error, 0);
        wait_cycles(4);
        nReset = 1'b1;
      end
    join
    wait_cycles(24);
    check_output("mr_valid_count", n_valid, 1);
    check_output("mr_start_count", n_start, 1);
    check_output("mr_end_count", n_end, 0);
    check_output("mr_err_count", n_err, 0);
    clear_counts();
    tx_bytes = '{8'h96};
    exp_bytes.push_back(8'h96);
    apply_stimulus(8, 8, 1'b0);
    wait_cycles(24);
    check_output("mr_fresh_valid", n_valid, 1);
    check_output("mr_fresh_end", n_end, 1);
    check_output("mr_fresh_sb_empty", exp_bytes.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_fs_receiver.md
# usb_fs_receiver

Full-speed (12 Mb/s) USB receive front-end. It oversamples the raw D+/D- pins at 4x on the 48 MHz USB clock, recovers bit timing, and NRZI-decodes the stream. It then detects SYNC, removes stuffed bits, assembles bytes LSB-first and detects EOP. It sits between the daughter-board USB pins and the packet/protocol logic in the USB bring-up top level.

## Interface
- SYNC_STAGES, 2, synchroniser flops per input line (≥2)
- Clk  in  1  48 MHz USB clock (PLL c0)
- nReset  in  1  asynchronous, active-low reset
- Enable  in  1  receiver enable; low forces IDLE
- USB_D_P  in  1  raw D+ pin (input side of the inout)
- USB_D_N  in  1  raw D- pin
- Line_State  out  2  synchronised line: 00 SE0, 01 J (D+ high), 10 K, 11 SE1
- Data  out  8  received byte, valid while Valid=1
- Valid  out  1  one-cycle pulse per byte
- Packet_Start  out  1  one-cycle pulse when SYNC completes
- Packet_End  out  1  one-cycle pulse on valid EOP
- Packet_Active  out  1  high from Packet_Start until End/abort
- Error  out  1  one-cycle pulse on any receive error

## Operation
- Reset: all outputs 0, Line_State 00, state IDLE, phase counter 0, previous-level register J.
- Each line passes through SYNC_STAGES flops. Line_State is registered from the last stage.
- DPLL: 2-bit phase counter, increments mod 4. It clears to 0 on any J↔K transition; SE0/SE1 edges do not resync. Sample strobe fires at phase==2.
- At each strobe: decoded bit = 1 if the sampled level equals the previous J/K level (no transition), else 0. Update the previous level.
- States:
  - IDLE: previous level forced J. First strobe sampling K → SYNC.
  - SYNC: count consecutive decoded 0s (the first K counts as one). A decoded 1 with count ≥5 → DATA and pulse Packet_Start. A decoded 1 with count <5, or an SE0 sample → IDLE, with no Error.
  - DATA: ones counter, 3 bits.
    - Decoded 1: increment.
    - Decoded 0 after six 1s: stuffed bit, discarded, counter cleared.
    - Decoded 1 after six 1s: stuff error → Error pulse, ABORT.
    - Otherwise shift the bit into bit 7 of the shift register (LSB first) and increment the 3-bit bit counter. On wrap to 0, Data ← shift register and Valid is pulsed.
    - SE0 sample → EOP. SE1 sample → Error, ABORT.
  - EOP: next strobe J → Packet_End pulse, IDLE. Error also pulses with Packet_End if the bit counter ≠0 (partial byte). Next strobe K or SE1 → Error, ABORT. Further SE0 strobes stay in EOP, up to 3; the 4th → Error, ABORT.
  - ABORT: Packet_Active low. Wait for a J strobe → IDLE. No Packet_End is issued.
- Enable low: immediate IDLE from any state. Packet_Active clears, no Packet_End or Error pulse. DPLL and Line_State keep running.
- Packet_Active is set with Packet_Start and cleared with Packet_End, Error, or Enable low.
- Error and Packet_End/Valid may coincide only in the partial-byte EOP case. Valid never coincides with Packet_End.

## Timing
- Pin to Line_State: SYNC_STAGES+1 cycles.
- Strobe of the last data bit → Valid asserted the next cycle. Data holds until the next Valid.
- Strobe of the SYNC final 1 → Packet_Start next cycle. The J strobe after SE0 → Packet_End next cycle.
- Nominal byte spacing is 32 cycles, minimum 28 (stuffing-free with ±1-cycle edge jitter).
- Tolerance: data correct for edge jitter of ±1 cycle and bit periods of 3–5 cycles between transitions.

## Structure
- Package usb_fs_pkg: line-state encodings (SE0/J/K/SE1), state enum (IDLE, SYNC, DATA, EOP, ABORT), STUFF_LIMIT=6, SYNC_MIN_ZEROS=5, EOP_MAX_SE0=3.
- Sub-module usb_fs_dpll: synchronisers, Line_State register, phase counter and sample strobe. The parent holds the decoder FSM, unstuffer and byte assembler.

## Test plan
- Reset asserted mid-traffic → all outputs 0 within the same cycle. After release, no Valid until a fresh SYNC.
- J idle, SYNC KJKJKJKK, byte 0x2D, SE0 SE0 J → Packet_Start, one Valid with Data=0x2D, Packet_End, Error never high.
- Bytes 0xFF 0xFF 0x01 with correct stuff bits → three Valids 0xFF, 0xFF, 0x01, no Error. Byte spacing of 36 cycles across stuffed bits.
- Seven undecoded 1s (no stuff bit) in the second byte → Error pulse, Packet_Active drops, no Packet_End. Recovers on the next packet.
- SYNC + 12 data bits + EOP → one Valid, Packet_End with coincident Error. Separately, SYNC + bytes 0xA5 0x3C with edges jittered ±1 cycle at random → both bytes correct.
- Enable deasserted during the second byte → Packet_Active 0 next cycle, no Valid/Packet_End/Error. Re-enable followed by a full packet → decoded normally.
